// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads a 1-cycle-latency instruction BRAM,
// predicts not-taken, absorbs decode stalls with a 1-entry hold buffer, redirects on mispredict/jalr.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 14,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   branch_wrong,
  input  logic [31:0]            branch_target,
  input  logic                   jalr_valid,
  input  logic [31:0]            jalr_target,
  output logic                   imem_en,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            instr_raw,
  output logic [31:0]            pc_out,
  output logic                   fetch_valid
);

  typedef enum logic [1:0] {
    ACT_FETCH,
    ACT_STALL,
    ACT_REDIRECT
  } action_e;

  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        kill;
  logic        hold_valid;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] fetch_pc;
  action_e     action;

  // NOTE: every signal assigned in an always_comb gets a default first so no path
  // leaves it unassigned; that is what keeps these blocks from inferring latches.
  always_comb begin
    redirect = rst && (branch_wrong || jalr_valid);
    target   = branch_wrong ? branch_target : jalr_target;
    action   = ACT_FETCH;
    if (redirect) begin
      action = ACT_REDIRECT;
    end else if (stall) begin
      action = ACT_STALL;
    end
    fetch_pc = redirect ? target : pc;
  end

  // Reset must also silence the BRAM, independent of the redirect/stall inputs.
  assign imem_en   = rst && (action != ACT_STALL);
  assign imem_addr = fetch_pc[IMEM_ADDR_W+1:2];

  // A redirect kills the wrong-path instruction presented in the same cycle.
  always_comb begin
    instr_raw   = NOP_INSTR;
    pc_out      = req_pc;
    fetch_valid = 1'b0;
    if (!redirect) begin
      if (hold_valid) begin
        instr_raw   = hold_instr;
        pc_out      = hold_pc;
        fetch_valid = 1'b1;
      end else if (!kill) begin
        instr_raw   = imem_rdata;
        fetch_valid = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= RESET_PC;
      req_pc     <= 32'h0000_0000;
      kill       <= 1'b1;
      hold_valid <= 1'b0;
    end else begin
      unique case (action)
        ACT_REDIRECT: begin
          pc         <= target + 32'd4;
          req_pc     <= target;
          kill       <= 1'b0;
          hold_valid <= 1'b0;
        end
        ACT_STALL: begin
          // The read result arriving next cycle was never requested; ignore it.
          kill <= 1'b1;
          if (!hold_valid && !kill) begin
            hold_valid <= 1'b1;
          end
        end
        default: begin
          pc         <= pc + 32'd4;
          req_pc     <= pc;
          kill       <= 1'b0;
          hold_valid <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the hold payload is qualified by hold_valid, so it needs no reset and
  // stays a plain enable-flop bank.
  always_ff @(posedge clk) begin
    if (action == ACT_STALL && !hold_valid) begin
      hold_instr <= instr_raw;
      hold_pc    <= pc_out;
    end
  end

  a_redirect_is_bubble: assert property (@(posedge clk) disable iff (!rst)
    (branch_wrong || jalr_valid) |-> (!fetch_valid && imem_en));

  a_stall_no_read: assert property (@(posedge clk) disable iff (!rst)
    (stall && !branch_wrong && !jalr_valid) |-> !imem_en);

  a_bubble_is_nop: assert property (@(posedge clk) disable iff (!rst)
    !fetch_valid |-> (instr_raw == NOP_INSTR));

endmodule
